keypad_entry: RTL

Downstream consumer of the 4x4 keypad scanner. Takes the scanner's raw `key`/`pressed` pair and debounces it into exactly one event per physical press. Digit keys (0-9) go into a 4-digit BCD entry buffer, and keys A-F act as edit/commit commands. The committed 16-bit BCD value and the live buffer feed the display and application logic.

---
 rtl/keypad_entry_if.sv | 22 ++
 rtl/keypad_entry.sv | 126 ++++++++++++
 2 files changed

// File: rtl/keypad_entry_if.sv
// Keypad entry bundle: raw scanner sample in, BCD entry buffer and event pulses out.
// The scanner side drives key/pressed as a level; there is no backpressure on any signal.
interface keypad_entry_if;
  logic [3:0]  key;
  logic        pressed;
  logic [15:0] digits;
  logic [2:0]  count;
  logic [15:0] value;
  logic        value_valid;
  logic        key_event;
  logic        err;

  modport master (
    output key, pressed,
    input  digits, count, value, value_valid, key_event, err
  );

  modport slave (
    input  key, pressed,
    output digits, count, value, value_valid, key_event, err
  );
endinterface

// File: rtl/keypad_entry.sv
// Debounces scanner key/pressed into one event per press and edits a 4-digit BCD buffer.
// Commit lands on the DEBOUNCE_CYCLES-th matching sample; all outputs registered; no backpressure.
module keypad_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  keypad_entry_if.slave kp
);

  typedef enum logic [2:0] {
    WAIT_REL,
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  key_q;
  logic [15:0] digits;
  logic [2:0]  count;
  logic [15:0] value;
  logic        value_valid;
  logic        key_event;
  logic        err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_REL;
      cnt         <= 8'd0;
      key_q       <= 4'd0;
      digits      <= 16'd0;
      count       <= 3'd0;
      value       <= 16'd0;
      value_valid <= 1'b0;
      key_event   <= 1'b0;
      err         <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      key_event   <= 1'b0;
      err         <= 1'b0;
      case (state)
        // a key still down when reset lifts must be released before it can count
        WAIT_REL: begin
          if (!kp.pressed) state <= IDLE;
        end
        IDLE: begin
          if (kp.pressed) begin
            state <= DEBOUNCE;
            key_q <= kp.key;
            cnt   <= 8'd1;
          end
        end
        DEBOUNCE: begin
          if (kp.pressed && (kp.key == key_q)) begin
            if (cnt == LAST) begin
              state     <= HELD;
              key_event <= 1'b1;
              if (key_q <= 4'h9) begin
                if (count < 3'd4) begin
                  digits <= {digits[11:0], key_q};
                  count  <= count + 3'd1;
                end else begin
                  err <= 1'b1;
                end
              end else if (key_q == 4'hA) begin
                if (count != 3'd0) begin
                  digits <= {4'h0, digits[15:4]};
                  count  <= count - 3'd1;
                end else begin
                  err <= 1'b1;
                end
              end else if (key_q == 4'hB) begin
                digits <= 16'd0;
                count  <= 3'd0;
              end else if (key_q == 4'hC) begin
                if (count != 3'd0) begin
                  value       <= digits;
                  value_valid <= 1'b1;
                  digits      <= 16'd0;
                  count       <= 3'd0;
                end else begin
                  err <= 1'b1;
                end
              end else begin
                err <= 1'b1;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else begin
            state <= IDLE;
          end
        end
        HELD: begin
          if (!kp.pressed) begin
            state <= RELEASE;
            cnt   <= 8'd1;
          end
        end
        RELEASE: begin
          if (kp.pressed) begin
            state <= HELD;
          end else if (cnt == LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= WAIT_REL;
      endcase
    end
  end

  assign kp.digits      = digits;
  assign kp.count       = count;
  assign kp.value       = value;
  assign kp.value_valid = value_valid;
  assign kp.key_event   = key_event;
  assign kp.err         = err;

endmodule
